// File: rtl/axi4_lite_cmd_issuer.sv
// Command stage in front of axi4_lite_top: buffers read/write commands in a small FIFO and
// replays them one at a time as single-cycle start strobes, waiting for completion in between.
module axi4_lite_cmd_issuer #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                     ACLK,
  input  logic                     ARESETN,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic                     cmd_we,
  input  logic [ADDR_W-1:0]        cmd_addr,
  input  logic [DATA_W-1:0]        cmd_wdata,
  output logic                     read_s,
  output logic                     write_s,
  output logic [ADDR_W-1:0]        address,
  output logic [DATA_W-1:0]        W_data,
  input  logic                     txn_done,
  output logic                     busy,
  output logic                     err_timeout,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int unsigned PtrW   = $clog2(DEPTH);
  localparam int unsigned CntW   = PtrW + 1;
  localparam int unsigned EntryW = 1 + ADDR_W + DATA_W;
  localparam int unsigned TmoW   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam bit          TmoEn  = (TIMEOUT != 0);
  localparam logic [TmoW-1:0] TmoLast = TmoW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StIssue, StWait} state_e;

  state_e              state_q, state_d;
  logic [EntryW-1:0]   mem_q [DEPTH];
  logic [PtrW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]     count_q, count_d;
  logic [TmoW-1:0]     tmo_q, tmo_d;
  logic [ADDR_W-1:0]   address_q, address_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                read_s_q, read_s_d;
  logic                write_s_q, write_s_d;
  logic                busy_q, busy_d;
  logic                err_q, err_d;

  logic                push, pop;
  logic [EntryW-1:0]   head;
  logic                head_we;
  logic [ADDR_W-1:0]   head_addr;
  logic [DATA_W-1:0]   head_wdata;

  // Readiness depends only on stored occupancy, never on a same-cycle pop.
  assign cmd_ready = (count_q < CntW'(DEPTH));
  assign push      = cmd_valid & cmd_ready;
  assign pop       = (state_q == StIdle) && (count_q != '0);

  assign head       = mem_q[rd_ptr_q];
  assign head_we    = head[EntryW-1];
  assign head_addr  = head[EntryW-2 -: ADDR_W];
  assign head_wdata = head[DATA_W-1:0];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
    unique case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    address_d = address_q;
    wdata_d   = wdata_q;
    tmo_d     = tmo_q;
    read_s_d  = 1'b0;
    write_s_d = 1'b0;
    err_d     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (pop) begin
          state_d   = StIssue;
          address_d = head_addr;
          wdata_d   = head_wdata;
          write_s_d = head_we;
          read_s_d  = ~head_we;
        end
      end
      StIssue: begin
        state_d = StWait;
        tmo_d   = '0;
      end
      StWait: begin
        if (txn_done) begin
          state_d = StIdle;
        end else if (TmoEn && (tmo_q == TmoLast)) begin
          state_d = StIdle;
          err_d   = 1'b1;
        end else begin
          tmo_d = tmo_q + TmoW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
    busy_d = (state_d != StIdle);
  end

  // Storage is not reset; an entry is only read after it has been written.
  always_ff @(posedge ACLK) begin
    if (push) mem_q[wr_ptr_q] <= {cmd_we, cmd_addr, cmd_wdata};
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q   <= StIdle;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      tmo_q     <= '0;
      address_q <= '0;
      wdata_q   <= '0;
      read_s_q  <= 1'b0;
      write_s_q <= 1'b0;
      busy_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      tmo_q     <= tmo_d;
      address_q <= address_d;
      wdata_q   <= wdata_d;
      read_s_q  <= read_s_d;
      write_s_q <= write_s_d;
      busy_q    <= busy_d;
      err_q     <= err_d;
    end
  end

  assign read_s      = read_s_q;
  assign write_s     = write_s_q;
  assign address     = address_q;
  assign W_data      = wdata_q;
  assign busy        = busy_q;
  assign err_timeout = err_q;
  assign fifo_count  = count_q;

endmodule

// File: tb/tb_axi4_lite_cmd_issuer.sv
// Directed bench for axi4_lite_cmd_issuer: one instance with a short timeout, one with timeout off.
module tb_axi4_lite_cmd_issuer;

  logic        ACLK, ARESETN;
  logic        cmd_valid, cmd_ready, cmd_we, read_s, write_s, txn_done, busy, err_timeout;
  logic [31:0] cmd_addr, cmd_wdata, address, W_data;
  logic [2:0]  fifo_count;
  logic        cmd_valid_b, cmd_ready_b, cmd_we_b, read_s_b, write_s_b, txn_done_b, busy_b;
  logic        err_timeout_b;
  logic [31:0] cmd_addr_b, cmd_wdata_b, address_b, W_data_b;
  logic [2:0]  fifo_count_b;

  int errors = 0;
  int checks = 0;

  axi4_lite_cmd_issuer #(.ADDR_W(32), .DATA_W(32), .DEPTH(4), .TIMEOUT(8)) dut (
    .ACLK(ACLK), .ARESETN(ARESETN), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_we(cmd_we), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .read_s(read_s),
    .write_s(write_s), .address(address), .W_data(W_data), .txn_done(txn_done),
    .busy(busy), .err_timeout(err_timeout), .fifo_count(fifo_count)
  );

  axi4_lite_cmd_issuer #(.ADDR_W(32), .DATA_W(32), .DEPTH(4), .TIMEOUT(0)) dut_nt (
    .ACLK(ACLK), .ARESETN(ARESETN), .cmd_valid(cmd_valid_b), .cmd_ready(cmd_ready_b),
    .cmd_we(cmd_we_b), .cmd_addr(cmd_addr_b), .cmd_wdata(cmd_wdata_b), .read_s(read_s_b),
    .write_s(write_s_b), .address(address_b), .W_data(W_data_b), .txn_done(txn_done_b),
    .busy(busy_b), .err_timeout(err_timeout_b), .fifo_count(fifo_count_b)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required normal completion");
    $fatal(1, "watchdog");
  end

  // Advance one edge and sample 1 time unit later; strobes must never overlap.
  task automatic tick();
    @(posedge ACLK);
    #1;
    checks++;
    if ((read_s && write_s) || (read_s_b && write_s_b)) begin
      errors++;
      $display("FAIL strobe_exclusive: got r/w=%0b%0b r_b/w_b=%0b%0b, required never both high",
               read_s, write_s, read_s_b, write_s_b);
    end
  endtask

  task automatic test_reset();
    ARESETN = 1'b0;
    tick();
    tick();
    checks++;
    if ({read_s, write_s, busy, err_timeout} !== 4'b0) begin
      errors++;
      $display("FAIL reset_flags: got r/w/busy/err=%b required 0000",
               {read_s, write_s, busy, err_timeout});
    end
    checks++;
    if (address !== 32'h0 || W_data !== 32'h0) begin
      errors++;
      $display("FAIL reset_data: got address=%0h W_data=%0h required 0/0", address, W_data);
    end
    checks++;
    if (fifo_count !== 3'd0) begin
      errors++;
      $display("FAIL reset_count: got %0d required 0", fifo_count);
    end
    ARESETN = 1'b1;
    tick();
    checks++;
    if (cmd_ready !== 1'b1 || cmd_ready_b !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: got %0b/%0b required 1/1", cmd_ready, cmd_ready_b);
    end
  endtask

  task automatic test_single_write();
    cmd_valid = 1'b1; cmd_we = 1'b1; cmd_addr = 32'h5; cmd_wdata = 32'h4;
    tick();  // push
    cmd_valid = 1'b0;
    checks++;
    if (fifo_count !== 3'd1 || write_s !== 1'b0) begin
      errors++;
      $display("FAIL wr_push: got count=%0d write_s=%0b required 1/0", fifo_count, write_s);
    end
    tick();  // pop, strobe
    checks++;
    if ({write_s, read_s, busy} !== 3'b101 || address !== 32'h5 || W_data !== 32'h4
        || fifo_count !== 3'd0) begin
      errors++;
      $display("FAIL wr_strobe: got w/r/busy=%b addr=%0h data=%0h count=%0d required 101/5/4/0",
               {write_s, read_s, busy}, address, W_data, fifo_count);
    end
    tick();  // enter WAIT
    checks++;
    if (write_s !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL wr_strobe_len: got write_s=%0b busy=%0b required 0/1", write_s, busy);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (address !== 32'h5 || W_data !== 32'h4 || busy !== 1'b1) begin
        errors++;
        $display("FAIL wr_hold: got addr=%0h data=%0h busy=%0b required 5/4/1",
                 address, W_data, busy);
      end
    end
    txn_done = 1'b1;
    tick();
    txn_done = 1'b0;
    checks++;
    if (busy !== 1'b0 || address !== 32'h5 || W_data !== 32'h4) begin
      errors++;
      $display("FAIL wr_done: got busy=%0b addr=%0h data=%0h required 0/5/4",
               busy, address, W_data);
    end
  endtask

  task automatic test_back_to_back_read();
    cmd_valid = 1'b1; cmd_we = 1'b0; cmd_addr = 32'h5; cmd_wdata = 32'hAA;
    tick();  // push 5
    cmd_addr = 32'h6;
    tick();  // push 6, pop 5
    cmd_valid = 1'b0;
    checks++;
    if ({read_s, write_s} !== 2'b10 || address !== 32'h5 || fifo_count !== 3'd1) begin
      errors++;
      $display("FAIL rd_strobe: got r/w=%b addr=%0h count=%0d required 10/5/1",
               {read_s, write_s}, address, fifo_count);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if ({read_s, write_s} !== 2'b00 || address !== 32'h5 || busy !== 1'b1) begin
        errors++;
        $display("FAIL rd_no_overlap: got r/w=%b addr=%0h busy=%0b required 00/5/1",
                 {read_s, write_s}, address, busy);
      end
    end
    txn_done = 1'b1;
    tick();
    txn_done = 1'b0;
    checks++;
    if (busy !== 1'b0 || read_s !== 1'b0) begin
      errors++;
      $display("FAIL rd_done: got busy=%0b read_s=%0b required 0/0", busy, read_s);
    end
    tick();  // next pop follows immediately
    checks++;
    if (read_s !== 1'b1 || address !== 32'h6 || fifo_count !== 3'd0) begin
      errors++;
      $display("FAIL rd_second: got read_s=%0b addr=%0h count=%0d required 1/6/0",
               read_s, address, fifo_count);
    end
    tick();
    txn_done = 1'b1;
    tick();
    txn_done = 1'b0;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL rd_second_done: got busy=%0b required 0", busy);
    end
  endtask

  task automatic test_timeout();
    int err_cnt = 0;
    int err_at  = -1;
    int rd_at   = -1;
    logic [31:0] rd_addr = '0;
    cmd_valid = 1'b1; cmd_we = 1'b1; cmd_addr = 32'h10; cmd_wdata = 32'h11;
    tick();
    cmd_we = 1'b0; cmd_addr = 32'h20;
    tick();  // strobe for write 0x10, read 0x20 queued
    cmd_valid = 1'b0;
    checks++;
    if (write_s !== 1'b1 || address !== 32'h10) begin
      errors++;
      $display("FAIL to_strobe: got write_s=%0b addr=%0h required 1/10", write_s, address);
    end
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (err_timeout) begin err_cnt++; err_at = i; end
      if (read_s && rd_at < 0) begin rd_at = i; rd_addr = address; end
    end
    checks++;
    if (err_cnt != 1 || err_at != 9) begin
      errors++;
      $display("FAIL to_pulse: got %0d pulses last at cycle %0d, required 1 at 9", err_cnt, err_at);
    end
    checks++;
    if (rd_at != 10 || rd_addr !== 32'h20) begin
      errors++;
      $display("FAIL to_next_issue: got cycle %0d addr=%0h required 10/20", rd_at, rd_addr);
    end
    txn_done = 1'b1;
    tick();
    txn_done = 1'b0;
    checks++;
    if (busy !== 1'b0 || err_timeout !== 1'b0) begin
      errors++;
      $display("FAIL to_done: got busy=%0b err=%0b required 0/0", busy, err_timeout);
    end
  endtask

  task automatic test_spurious_done();
    txn_done = 1'b1;
    tick();
    checks++;
    if ({busy, read_s, write_s} !== 3'b000 || fifo_count !== 3'd0) begin
      errors++;
      $display("FAIL sp_idle: got busy/r/w=%b count=%0d required 000/0",
               {busy, read_s, write_s}, fifo_count);
    end
    cmd_valid = 1'b1; cmd_we = 1'b1; cmd_addr = 32'h7; cmd_wdata = 32'h77;
    tick();
    cmd_valid = 1'b0;
    tick();  // pop with done still high
    checks++;
    if (write_s !== 1'b1 || busy !== 1'b1 || address !== 32'h7) begin
      errors++;
      $display("FAIL sp_strobe: got write_s=%0b busy=%0b addr=%0h required 1/1/7",
               write_s, busy, address);
    end
    tick();  // ISSUE edge sees done, must still go to WAIT
    txn_done = 1'b0;
    checks++;
    if (write_s !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL sp_issue: got write_s=%0b busy=%0b required 0/1", write_s, busy);
    end
    tick();
    checks++;
    if (busy !== 1'b1 || write_s !== 1'b0) begin
      errors++;
      $display("FAIL sp_wait: got busy=%0b write_s=%0b required 1/0", busy, write_s);
    end
    txn_done = 1'b1;
    tick();
    txn_done = 1'b0;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL sp_done: got busy=%0b required 0", busy);
    end
  endtask

  task automatic test_fifo_full();
    int acc = 0;
    logic acc_now;
    logic err_seen = 1'b0;
    logic [31:0] issued[$];
    cmd_valid_b = 1'b1; cmd_we_b = 1'b0; cmd_addr_b = 32'h1; cmd_wdata_b = 32'h0;
    for (int i = 0; i < 10; i++) begin
      acc_now = cmd_ready_b && cmd_valid_b;
      tick();
      if (acc_now) begin
        acc++;
        if (acc == 6) cmd_valid_b = 1'b0;
        else cmd_addr_b = 32'(acc + 1);
      end
      if (read_s_b) issued.push_back(address_b);
      if (err_timeout_b) err_seen = 1'b1;
    end
    checks++;
    if (acc != 5 || fifo_count_b !== 3'd4 || cmd_ready_b !== 1'b0 || busy_b !== 1'b1) begin
      errors++;
      $display("FAIL ff_full: got accepted=%0d count=%0d ready=%0b busy=%0b required 5/4/0/1",
               acc, fifo_count_b, cmd_ready_b, busy_b);
    end
    checks++;
    if (err_seen !== 1'b0) begin
      errors++;
      $display("FAIL ff_no_timeout: got err_timeout pulse, required none when disabled");
    end
    txn_done_b = busy_b && !read_s_b;
    for (int i = 0; i < 80 && !(issued.size() == 6 && !busy_b); i++) begin
      acc_now = cmd_ready_b && cmd_valid_b;
      tick();
      if (acc_now) begin
        acc++;
        if (acc == 6) cmd_valid_b = 1'b0;
        else cmd_addr_b = 32'(acc + 1);
      end
      if (read_s_b) issued.push_back(address_b);
      txn_done_b = busy_b && !read_s_b;
    end
    txn_done_b = 1'b0;
    checks++;
    if (acc != 6 || issued.size() != 6) begin
      errors++;
      $display("FAIL ff_drain: got accepted=%0d issued=%0d required 6/6", acc, issued.size());
    end
    for (int k = 0; k < issued.size(); k++) begin
      checks++;
      if (issued[k] !== 32'(k + 1)) begin
        errors++;
        $display("FAIL ff_order[%0d]: got addr=%0h required %0h", k, issued[k], k + 1);
      end
    end
  endtask

  task automatic test_reset_mid_wait();
    logic seen = 1'b0;
    cmd_valid = 1'b1; cmd_we = 1'b1; cmd_addr = 32'h30; cmd_wdata = 32'h3;
    tick();
    cmd_addr = 32'h31;
    tick();
    cmd_addr = 32'h32;
    tick();
    cmd_valid = 1'b0;
    tick();
    checks++;
    if (fifo_count !== 3'd2 || busy !== 1'b1) begin
      errors++;
      $display("FAIL rst_pre: got count=%0d busy=%0b required 2/1", fifo_count, busy);
    end
    #2 ARESETN = 1'b0;
    #1;
    checks++;
    if ({read_s, write_s, busy, err_timeout} !== 4'b0 || fifo_count !== 3'd0) begin
      errors++;
      $display("FAIL rst_async: got r/w/busy/err=%b count=%0d required 0000/0",
               {read_s, write_s, busy, err_timeout}, fifo_count);
    end
    checks++;
    if (address !== 32'h0 || W_data !== 32'h0) begin
      errors++;
      $display("FAIL rst_async_data: got addr=%0h data=%0h required 0/0", address, W_data);
    end
    tick();
    ARESETN = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (read_s || write_s || busy) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0 || fifo_count !== 3'd0) begin
      errors++;
      $display("FAIL rst_discard: got activity=%0b count=%0d required 0/0", seen, fifo_count);
    end
  endtask

  initial begin
    ARESETN = 1'b0;
    cmd_valid = 1'b0; cmd_we = 1'b0; cmd_addr = '0; cmd_wdata = '0; txn_done = 1'b0;
    cmd_valid_b = 1'b0; cmd_we_b = 1'b0; cmd_addr_b = '0; cmd_wdata_b = '0; txn_done_b = 1'b0;
    test_reset();
    test_single_write();
    test_back_to_back_read();
    test_timeout();
    test_spurious_done();
    test_fifo_full();
    test_reset_mid_wait();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
